// File: rtl/gol_pkg.sv
`default_nettype none
// ============================================================================
// Package     : gol_pkg
// Description : Shared constants and types for the life grid and its pattern
//               loader: grid geometry, loader state encoding, and helpers
//               for word count and word-index width.
// Revision    : 1.0 - initial release
// ============================================================================
package gol_pkg;

    // Grid geometry shared with the grid top.
    localparam int CELLS_X = 32;
    localparam int CELLS_Y = CELLS_X / 16 * 9;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_COMMIT = 3'd2,
        ST_SETTLE = 3'd3,
        ST_PULSE  = 3'd4
    } loader_state_t;

    // Number of stream words making up one full frame.
    function automatic int gol_words(input int cells_x, input int cells_y, input int word_w);
        return cells_x * cells_y / word_w;
    endfunction

    // Word-index width; a one-word frame still gets a 1-bit index.
    function automatic int gol_idx_w(input int words);
        return (words > 1) ? $clog2(words) : 1;
    endfunction

endpackage : gol_pkg
`default_nettype wire

// File: rtl/gol_frame_buffer.sv
`default_nettype none
// ============================================================================
// Module      : gol_frame_buffer
// Description : Shadow buffer for one cell frame. Written one stream word at
//               a time by word index; read out as the whole frame at once.
// Ports       : clk   - clock
//               we    - write enable for this cycle's word
//               k     - word index to write
//               data  - word contents (bit b -> flat cell k*WORD_W+b)
//               frame - full frame, row-major, LSB = lowest column
// Revision    : 1.0 - initial release
// ============================================================================
module gol_frame_buffer #(
    parameter int CELLS_X = 32,
    parameter int CELLS_Y = 18,
    parameter int WORD_W  = 8,
    parameter int KW      = 7
) (
    input  logic                            clk,
    input  logic                            we,
    input  logic [KW-1:0]                   k,
    input  logic [WORD_W-1:0]               data,
    output logic [CELLS_Y-1:0][CELLS_X-1:0] frame
);
    import gol_pkg::*;

    localparam int WORDS = gol_words(CELLS_X, CELLS_Y, WORD_W);

    // Word k occupies flat bits k*WORD_W +: WORD_W, which is exactly the
    // row-major flattening of the [row][col] frame, so the read is a rename.
    logic [WORDS-1:0][WORD_W-1:0] r_mem;

    // No reset: contents only matter once a complete frame has been written.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[k] <= data;
        end
    end

    assign frame = r_mem;

endmodule : gol_frame_buffer
`default_nettype wire

// File: rtl/gol_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module      : gol_pattern_loader
// Description : Assembles a host word stream into a full cell frame, then
//               presents it on cells_in and strobes overwrite so the grid
//               latches it.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - stream handshake
//               in_data, in_first   - word payload, first-word-of-frame mark
//               cells_in            - registered frame to the grid
//               overwrite           - grid load strobe (OVR_CYCLES long)
//               frame_done          - one-cycle pulse at load completion
//               sync_err            - sticky framing error
// Revision    : 1.0 - initial release
// ============================================================================
module gol_pattern_loader #(
    parameter int CELLS_X    = gol_pkg::CELLS_X,
    parameter int CELLS_Y    = gol_pkg::CELLS_Y,
    parameter int WORD_W     = 8,
    parameter int OVR_CYCLES = 2
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [WORD_W-1:0]               in_data,
    input  logic                            in_first,
    output logic [CELLS_Y-1:0][CELLS_X-1:0] cells_in,
    output logic                            overwrite,
    output logic                            frame_done,
    output logic                            sync_err
);
    import gol_pkg::*;

    localparam int WORDS = gol_words(CELLS_X, CELLS_Y, WORD_W);
    localparam int KW    = gol_idx_w(WORDS);
    localparam int OW    = (OVR_CYCLES > 1) ? $clog2(OVR_CYCLES) : 1;

    loader_state_t                   r_state;
    logic [KW-1:0]                   r_k;
    logic [OW-1:0]                   r_ovr_cnt;
    logic                            r_ready;
    logic                            r_overwrite;
    logic                            r_frame_done;
    logic                            r_sync_err;
    logic [CELLS_Y-1:0][CELLS_X-1:0] r_cells;

    logic                            w_accept;
    logic                            w_wr_en;
    logic [KW-1:0]                   w_wr_k;
    logic                            w_last;
    logic [CELLS_Y-1:0][CELLS_X-1:0] w_frame;

    assign w_accept = in_valid && in_ready;
    // In IDLE only a first-word starts a frame; in LOAD every word is kept.
    assign w_wr_en  = w_accept && ((r_state == ST_LOAD) || in_first);
    // A first-word always lands at index 0, restarting any partial frame.
    assign w_wr_k   = in_first ? '0 : r_k;
    assign w_last   = (w_wr_k == KW'(WORDS - 1));

    gol_frame_buffer #(
        .CELLS_X (CELLS_X),
        .CELLS_Y (CELLS_Y),
        .WORD_W  (WORD_W),
        .KW      (KW)
    ) u_frame_buffer (
        .clk   (clk),
        .we    (w_wr_en),
        .k     (w_wr_k),
        .data  (in_data),
        .frame (w_frame)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_k          <= '0;
            r_ovr_cnt    <= '0;
            r_ready      <= 1'b0;
            r_overwrite  <= 1'b0;
            r_frame_done <= 1'b0;
            r_sync_err   <= 1'b0;
            r_cells      <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                ST_IDLE, ST_LOAD: begin
                    r_ready <= 1'b1;
                    // Stray word in IDLE or unexpected restart in LOAD.
                    if (w_accept && ((r_state == ST_IDLE) != in_first)) begin
                        r_sync_err <= 1'b1;
                    end
                    if (w_wr_en) begin
                        if (w_last) begin
                            r_state <= ST_COMMIT;
                            r_ready <= 1'b0;
                            r_k     <= '0;
                        end else begin
                            r_state <= ST_LOAD;
                            r_k     <= w_wr_k + KW'(1);
                        end
                    end
                end
                ST_COMMIT: begin
                    // Whole frame moves in one edge, a cycle ahead of overwrite.
                    r_cells <= w_frame;
                    r_state <= ST_SETTLE;
                end
                ST_SETTLE: begin
                    r_overwrite <= 1'b1;
                    r_ovr_cnt   <= OW'(OVR_CYCLES - 1);
                    r_state     <= ST_PULSE;
                end
                ST_PULSE: begin
                    if (r_ovr_cnt == '0) begin
                        r_overwrite  <= 1'b0;
                        r_frame_done <= 1'b1;
                        r_ready      <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_ovr_cnt <= r_ovr_cnt - OW'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    // Gated by rst so nothing is offered while reset is held.
    assign in_ready   = r_ready && !rst;
    assign cells_in   = r_cells;
    assign overwrite  = r_overwrite;
    assign frame_done = r_frame_done;
    assign sync_err   = r_sync_err;

endmodule : gol_pattern_loader
`default_nettype wire

// File: tb/tb_gol_pattern_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_gol_pattern_loader
// Description : Self-checking bench for gol_pattern_loader. A frame-level
//               model maps accepted words to cells by flat-index arithmetic
//               and tracks framing errors; monitors time overwrite and
//               frame_done against the last accepted word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_gol_pattern_loader;
    localparam int CX  = gol_pkg::CELLS_X;
    localparam int CY  = gol_pkg::CELLS_Y;
    localparam int WW  = 8;
    localparam int OVR = 2;
    localparam int NW  = CX * CY / WW;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_first = 1'b0;
    logic [WW-1:0]      in_data = '0;
    logic               in_ready;
    logic               overwrite;
    logic               frame_done;
    logic               sync_err;
    logic [CY-1:0][CX-1:0] cells_in;

    always #5 clk = ~clk;

    gol_pattern_loader #(
        .CELLS_X    (CX),
        .CELLS_Y    (CY),
        .WORD_W     (WW),
        .OVR_CYCLES (OVR)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_first   (in_first),
        .cells_in   (cells_in),
        .overwrite  (overwrite),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    int n_vec = 0;
    int n_err = 0;

    // Edge counter: after edge E the value is the index of E.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled on the falling edge.
    int   ow_pulses = 0;
    int   fd_pulses = 0;
    int   rise_cyc  = -1;
    int   fall_cyc  = -1;
    int   fd_cyc    = -1;
    logic ow_prev   = 1'b0;
    always @(negedge clk) begin
        if (overwrite === 1'b1 && ow_prev === 1'b0) begin
            ow_pulses++;
            rise_cyc = cyc;
        end
        if (overwrite === 1'b0 && ow_prev === 1'b1) fall_cyc = cyc;
        if (frame_done === 1'b1) begin
            fd_pulses++;
            fd_cyc = cyc;
        end
        ow_prev = overwrite;
    end

    // ---------------- reference model ----------------
    logic [WW-1:0]    m_buf [NW];
    int               m_n = 0;
    bit               m_in_frame = 0;
    bit               m_err = 0;
    logic [CY-1:0][CX-1:0] m_cells = '0;
    int               last_acc = 0;

    task automatic model_reset();
        m_n = 0; m_in_frame = 0; m_err = 0; m_cells = '0;
    endtask

    task automatic model_accept(input logic [WW-1:0] d, input bit first);
        if (first) begin
            if (m_in_frame) m_err = 1;
            m_in_frame = 1;
            m_n = 0;
        end else if (!m_in_frame) begin
            m_err = 1;
            return;
        end
        m_buf[m_n] = d;
        m_n++;
        if (m_n == NW) begin
            for (int f = 0; f < CX * CY; f++)
                m_cells[f / CX][f % CX] = m_buf[f / WW][f % WW];
            m_in_frame = 0;
        end
    endtask

    // ---------------- helpers ----------------
    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_cells(input string name, input logic [CY-1:0][CX-1:0] exp);
        n_vec++;
        if (cells_in !== exp) begin
            n_err++;
            for (int r = 0; r < CY; r++) begin
                if (cells_in[r] !== exp[r]) begin
                    $display("FAIL %s: cells_in row %0d got %h expected %h", name, r, cells_in[r], exp[r]);
                    break;
                end
            end
        end
    endtask

    function automatic logic [WW-1:0] gen(input int kind, input int k);
        case (kind)
            0:       return (k % 2 == 0) ? 8'hA5 : 8'h3C;
            1:       return WW'($urandom);
            2:       return '1;
            default: return '0;
        endcase
    endfunction

    task automatic send_word(input logic [WW-1:0] d, input bit first, input bit gappy,
                             output int stalls);
        bit acc;
        stalls = 0;
        for (int t = 0; t < 200; t++) begin
            step();
            if (gappy && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                acc = 0;
            end else begin
                in_valid = 1'b1;
                in_data  = d;
                in_first = first;
                acc = in_ready;
                if (!acc) stalls++;
            end
            @(posedge clk); #1;
            if (acc) begin
                last_acc = cyc;
                model_accept(d, first);
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL send_word: not accepted within 200 cycles");
    endtask

    task automatic send_frame(input int kind, input bit gappy, input bit hold, output int stalls0);
        int s;
        stalls0 = 0;
        for (int k = 0; k < NW; k++) begin
            send_word(gen(kind, k), k == 0, gappy, s);
            if (k == 0) stalls0 = s;
        end
        if (!hold) in_valid = 1'b0;
    endtask

    task automatic finish_frame(input string name, input int ow0, input int fd0, input int npulse);
        for (int t = 0; t < 60 && fd_pulses < fd0 + npulse; t++) step();
        check({name, " frame_done count"}, fd_pulses - fd0, npulse);
        check({name, " overwrite pulses"}, ow_pulses - ow0, npulse);
        check({name, " accept->rise"}, rise_cyc - last_acc, 2);
        check({name, " overwrite width"}, fall_cyc - rise_cyc, OVR);
        check({name, " frame_done at fall"}, fd_cyc, fall_cyc);
        check({name, " in_ready after done"}, int'(in_ready), 1);
        check({name, " sync_err"}, int'(sync_err), int'(m_err));
        check_cells({name, " cells_in"}, m_cells);
        step();
        check({name, " frame_done one cycle"}, int'(frame_done), 0);
    endtask

    task automatic reset_on();
        rst = 1'b1;
        in_valid = 1'b0;
        in_first = 1'b0;
        repeat (2) @(posedge clk);
        step();
        model_reset();
    endtask

    typedef struct {
        int   row;
        int   col;
        logic exp;
    } probe_t;
    probe_t probes [14];

    // ---------------- main sequence ----------------
    initial begin
        int s, ow0, fd0, t;

        // Expected cell values for the A5/3C frame, worked out by hand.
        probes[0]  = '{0, 0, 1'b1};  probes[1]  = '{0, 1, 1'b0};
        probes[2]  = '{0, 2, 1'b1};  probes[3]  = '{0, 3, 1'b0};
        probes[4]  = '{0, 4, 1'b0};  probes[5]  = '{0, 5, 1'b1};
        probes[6]  = '{0, 6, 1'b0};  probes[7]  = '{0, 7, 1'b1};
        probes[8]  = '{0, 8, 1'b0};  probes[9]  = '{0, 10, 1'b1};
        probes[10] = '{1, 0, 1'b1};  probes[11] = '{17, 31, 1'b0};
        probes[12] = '{17, 29, 1'b1}; probes[13] = '{9, 25, 1'b0};

        // Reset values.
        reset_on();
        check("reset in_ready", int'(in_ready), 0);
        check("reset overwrite", int'(overwrite), 0);
        check("reset frame_done", int'(frame_done), 0);
        check("reset sync_err", int'(sync_err), 0);
        check_cells("reset cells_in", '0);
        rst = 1'b0;
        step();

        // Full frame, valid held high.
        ow0 = ow_pulses; fd0 = fd_pulses;
        send_frame(0, 0, 0, s);
        finish_frame("full", ow0, fd0, 1);
        foreach (probes[i])
            check($sformatf("probe r%0d c%0d", probes[i].row, probes[i].col),
                  int'(cells_in[probes[i].row][probes[i].col]), int'(probes[i].exp));

        // Same pattern with a gappy valid, then random data with gaps.
        ow0 = ow_pulses; fd0 = fd_pulses;
        send_frame(0, 1, 0, s);
        finish_frame("gappy", ow0, fd0, 1);
        ow0 = ow_pulses; fd0 = fd_pulses;
        send_frame(1, 1, 0, s);
        finish_frame("gappy random", ow0, fd0, 1);

        // Idle garbage.
        reset_on();
        rst = 1'b0;
        step();
        ow0 = ow_pulses;
        for (int i = 0; i < 3; i++) begin
            send_word(WW'($urandom), 1'b0, 1'b0, s);
            check($sformatf("garbage %0d stalls", i), s, 0);
        end
        in_valid = 1'b0;
        repeat (6) step();
        check("garbage sync_err", int'(sync_err), 1);
        check("garbage overwrite", ow_pulses - ow0, 0);
        check_cells("garbage cells_in", '0);

        // Mid-frame restart.
        reset_on();
        rst = 1'b0;
        step();
        ow0 = ow_pulses; fd0 = fd_pulses;
        for (int k = 0; k < 10; k++) send_word(WW'($urandom), k == 0, 1'b0, s);
        send_frame(1, 0, 0, s);
        check("restart model err", int'(m_err), 1);
        finish_frame("restart", ow0, fd0, 1);

        // Reset on the first overwrite cycle.
        reset_on();
        rst = 1'b0;
        step();
        fd0 = fd_pulses;
        send_frame(1, 0, 0, s);
        for (t = 0; t < 20 && overwrite !== 1'b1; t++) step();
        check("pulse-reset overwrite seen", int'(overwrite), 1);
        rst = 1'b1;
        step();
        model_reset();
        check("pulse-reset overwrite", int'(overwrite), 0);
        check("pulse-reset frame_done", int'(frame_done), 0);
        check("pulse-reset in_ready", int'(in_ready), 0);
        check_cells("pulse-reset cells_in", '0);
        rst = 1'b0;
        step();
        check("pulse-reset in_ready after", int'(in_ready), 1);
        repeat (4) step();
        check("pulse-reset no frame_done", fd_pulses - fd0, 0);

        // Back-to-back frames with valid continuously high.
        ow0 = ow_pulses; fd0 = fd_pulses;
        send_frame(2, 0, 1, s);
        send_frame(3, 0, 0, s);
        check("b2b ready-low cycles", s, 2 + OVR);
        finish_frame("b2b", ow0, fd0, 2);
        check_cells("b2b final zeros", '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule : tb_gol_pattern_loader
`default_nettype wire
